// File: rtl/adder257_arbiter_pkg.sv
// Shared types and helpers for the 257-bit adder arbiter.
// Operand/result widths, tag record and the rotate-priority pick function.
package adder257_arb_pkg;

    localparam int LIMB_W    = 64;
    localparam int NUM_LIMBS = 4;
    localparam int OPERAND_W = LIMB_W * NUM_LIMBS + 1;
    localparam int RESULT_W  = OPERAND_W + 1;

    // Tags and picks are sized for the largest supported requester count.
    localparam int MAX_REQ   = 4;
    localparam int TAG_IDX_W = 2;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    typedef struct packed {
        logic                 found;
        logic [TAG_IDX_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                      input logic [TAG_IDX_W-1:0] ptr,
                                      input int                   num_req);
        pick_t res;
        int    cand;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand = (int'(ptr) + k) % num_req;
            if (k < num_req && !res.found && valid[cand[TAG_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[TAG_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder257_arbiter_if.sv
// Requester-side bus of the adder arbiter: request handshake plus shared result.
interface adder257_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import adder257_arb_pkg::*;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][OPERAND_W-1:0] req_a;
    logic [NUM_REQ-1:0][OPERAND_W-1:0] req_b;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [RESULT_W-1:0]               rsp_sum;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_sum
    );

endinterface

// File: rtl/adder257_arbiter_rr_arbiter.sv
// Round-robin arbiter: pointer register plus rotate-priority pick.
// Grant is combinational from req_valid; the pointer moves past each grantee.
module rr_arbiter
    import adder257_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    pick_t            pick;

    always_comb begin
        pick        = rr_pick(MAX_REQ'(req_valid), TAG_IDX_W'(ptr_reg), NUM_REQ);
        grant_valid = pick.found;
        grant_idx   = pick.idx[IDX_W-1:0];
        grant       = pick.found ? (NUM_REQ'(1) << pick.idx) : '0;
        ptr_next    = ptr_reg;
        if (pick.found) begin
            ptr_next = (int'(pick.idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/adder257_arbiter.sv
// Shares one fixed-latency 257-bit adder between NUM_REQ requesters and routes sums back.
// Optional protocol checking (sticky err + assertions) under macro ADDER_ARB_CHECK_EN.
module adder257_arbiter
    import adder257_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int ADDER_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder257_arbiter_if.slave    bus,
    output logic                 adder_dv,
    output logic [OPERAND_W-1:0] adder_a,
    output logic [OPERAND_W-1:0] adder_b,
    input  logic                 adder_o_dv,
    input  logic [RESULT_W-1:0]  adder_c,
    output logic                 err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ADDER_LATENCY + 1);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (bus.req_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign bus.req_ready = grant;

    // Issue stage: operands hold their last value while idle.
    logic                 adder_dv_reg;
    logic [OPERAND_W-1:0] adder_a_reg;
    logic [OPERAND_W-1:0] adder_b_reg;
    logic [IDX_W-1:0]     issue_idx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            adder_dv_reg  <= 1'b0;
            adder_a_reg   <= '0;
            adder_b_reg   <= '0;
            issue_idx_reg <= '0;
        end else begin
            adder_dv_reg <= grant_valid;
            if (grant_valid) begin
                adder_a_reg   <= bus.req_a[grant_idx];
                adder_b_reg   <= bus.req_b[grant_idx];
                issue_idx_reg <= grant_idx;
            end
        end
    end

    assign adder_dv = adder_dv_reg;
    assign adder_a  = adder_a_reg;
    assign adder_b  = adder_b_reg;

    // Tag stage 0 captures the issue strobe one cycle later so that the last
    // stage is valid in exactly the cycle the adder raises o_dv.
    tag_t [ADDER_LATENCY-1:0] tag_pipe_reg;
    tag_t [ADDER_LATENCY-1:0] tag_pipe_next;
    tag_t                     tag_last;

    for (genvar gi = 0; gi < ADDER_LATENCY; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign tag_pipe_next[gi] = '{valid: adder_dv_reg, idx: TAG_IDX_W'(issue_idx_reg)};
        end else begin : g_shift
            assign tag_pipe_next[gi] = tag_pipe_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe_reg <= '0;
        end else begin
            tag_pipe_reg <= tag_pipe_next;
        end
    end

    assign tag_last = tag_pipe_reg[ADDER_LATENCY-1];

    // A valid tag always implies a non-zero count; the count guards against stale tags.
    logic [CNT_W-1:0] outstanding_reg;
    logic             ret_fire;

    assign ret_fire = adder_o_dv && tag_last.valid && (outstanding_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
        end else begin
            case ({adder_dv_reg, ret_fire})
                2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
                2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    logic [NUM_REQ-1:0]  rsp_valid_reg;
    logic [RESULT_W-1:0] rsp_sum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= '0;
            rsp_sum_reg   <= '0;
        end else begin
            rsp_valid_reg <= ret_fire ? (NUM_REQ'(1) << tag_last.idx) : '0;
            if (ret_fire) begin
                rsp_sum_reg <= adder_c;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_sum   = rsp_sum_reg;

`ifdef ADDER_ARB_CHECK_EN
    logic                              err_reg;
    logic [NUM_REQ-1:0]                wait_reg;
    logic [NUM_REQ-1:0][OPERAND_W-1:0] prev_a_reg;
    logic [NUM_REQ-1:0][OPERAND_W-1:0] prev_b_reg;
    logic                              orphan_dv;
    logic                              missing_dv;
    logic                              unstable;

    always_comb begin
        orphan_dv  = adder_o_dv && !tag_last.valid;
        missing_dv = tag_last.valid && !adder_o_dv;
        unstable   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wait_reg[i] && bus.req_valid[i] &&
                (bus.req_a[i] != prev_a_reg[i] || bus.req_b[i] != prev_b_reg[i])) begin
                unstable = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg    <= 1'b0;
            wait_reg   <= '0;
            prev_a_reg <= '0;
            prev_b_reg <= '0;
        end else begin
            wait_reg   <= bus.req_valid & ~grant;
            prev_a_reg <= bus.req_a;
            prev_b_reg <= bus.req_b;
            if (orphan_dv || missing_dv || unstable) begin
                err_reg <= 1'b1;
            end
            assert (!orphan_dv);
            assert (!missing_dv);
            assert (!unstable);
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder257_arbiter.sv
// Directed bench for adder257_arbiter with a behavioural 4-stage adder and a response scoreboard.
`timescale 1ns/1ps
module tb_adder257_arbiter;
    import adder257_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int LAT     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 adder_dv;
    logic [OPERAND_W-1:0] adder_a;
    logic [OPERAND_W-1:0] adder_b;
    logic                 adder_o_dv;
    logic [RESULT_W-1:0]  adder_c;
    logic                 err;
    logic                 inject_o_dv;

    adder257_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    adder257_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ADDER_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .adder_dv   (adder_dv),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_o_dv (adder_o_dv),
        .adder_c    (adder_c),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural adder: LAT register stages, not cleared by rst.
    logic [LAT-1:0]      m_dv = '0;
    logic [RESULT_W-1:0] m_sum [LAT];

    always @(posedge clk) begin
        m_dv     <= {m_dv[LAT-2:0], (adder_dv === 1'b1)};
        m_sum[0] <= {1'b0, adder_a} + {1'b0, adder_b};
        for (int i = 1; i < LAT; i++) m_sum[i] <= m_sum[i-1];
    end

    assign adder_o_dv = m_dv[LAT-1] | inject_o_dv;
    assign adder_c    = m_sum[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [RESULT_W-1:0] act,
                         input logic [RESULT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int                  req;
        logic [RESULT_W-1:0] sum;
    } rsp_t;

    rsp_t exp_q [$];
    rsp_t mon_e;

    task automatic push_exp(input int req, input logic [RESULT_W-1:0] sum);
        rsp_t e;
        e.req = req;
        e.sum = sum;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (bus.rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", RESULT_W'(bus.rsp_valid), '0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_idx", RESULT_W'(bus.rsp_valid), RESULT_W'(1) << mon_e.req);
                check("rsp_sum", bus.rsp_sum, mon_e.sum);
                $display("rsp req=%0d sum=%0h", mon_e.req, bus.rsp_sum);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) step();
        check("drain_empty", RESULT_W'(exp_q.size()), '0);
    endtask

    task automatic run_single(input int r, input logic [OPERAND_W-1:0] a,
                              input logic [OPERAND_W-1:0] b, input logic [RESULT_W-1:0] sum);
        int got;
        int lat;
        bus.req_a[r]  = a;
        bus.req_b[r]  = b;
        bus.req_valid = NUM_REQ'(1) << r;
        #1;
        got = 0;
        for (int w = 0; w < 8 && got == 0; w++) begin
            if (bus.req_ready[r]) got = 1;
            else step();
        end
        check("single_grant", RESULT_W'(got), RESULT_W'(1));
        if (got == 1) begin
            check("single_ready_onehot", RESULT_W'(bus.req_ready), RESULT_W'(1) << r);
            push_exp(r, sum);
            step();
            bus.req_valid = '0;
            check("single_dv", RESULT_W'(adder_dv), RESULT_W'(1));
            check("single_a", RESULT_W'(adder_a), RESULT_W'(a));
            check("single_b", RESULT_W'(adder_b), RESULT_W'(b));
            lat = 0;
            for (int k = 2; k < 10; k++) begin
                step();
                if (k == 2) check("single_dv_pulse", RESULT_W'(adder_dv), '0);
                if (lat == 0 && bus.rsp_valid[r] === 1'b1) lat = k;
            end
            check("single_latency", RESULT_W'(lat), RESULT_W'(LAT + 2));
            check("idle_hold_a", RESULT_W'(adder_a), RESULT_W'(a));
            $display("single req=%0d a=%0h b=%0h latency=%0d", r, a, b, lat);
        end
        bus.req_valid = '0;
    endtask

    typedef struct {
        int                   req;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
        logic [RESULT_W-1:0]  sum;
    } vec_t;

    vec_t vecs [6];

    initial begin
        rst           = 1'b1;
        inject_o_dv   = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        vecs[0] = '{0, OPERAND_W'(1), OPERAND_W'(2), RESULT_W'(3)};
        vecs[1] = '{0, {OPERAND_W{1'b1}}, OPERAND_W'(1), {1'b1, {OPERAND_W{1'b0}}}};
        vecs[2] = '{1, OPERAND_W'(5), OPERAND_W'(7), RESULT_W'(12)};
        vecs[3] = '{1, {1'b1, {(OPERAND_W-1){1'b0}}}, {1'b1, {(OPERAND_W-1){1'b0}}},
                    {1'b1, {OPERAND_W{1'b0}}}};
        vecs[4] = '{0, {OPERAND_W{1'b1}}, {OPERAND_W{1'b1}}, {1'b1, {(OPERAND_W-1){1'b1}}, 1'b0}};
        vecs[5] = '{1, OPERAND_W'(64'hFFFF_FFFF_FFFF_FFFF), OPERAND_W'(1),
                    {{(RESULT_W-65){1'b0}}, 1'b1, 64'h0}};

        do_reset();
        check("reset_ready", RESULT_W'(bus.req_ready), '0);
        check("reset_rsp_valid", RESULT_W'(bus.rsp_valid), '0);
        check("reset_adder_dv", RESULT_W'(adder_dv), '0);
        check("reset_adder_a", RESULT_W'(adder_a), '0);
        check("reset_adder_b", RESULT_W'(adder_b), '0);
        check("reset_rsp_sum", bus.rsp_sum, '0);
        check("reset_err", RESULT_W'(err), '0);
        check("reset_outstanding", RESULT_W'(dut.outstanding_reg), '0);

        for (int v = 0; v < 6; v++) run_single(vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].sum);
        drain();

        // Both requesters valid: grants alternate, dv every cycle.
        do_reset();
        bus.req_a[0] = OPERAND_W'(0);
        bus.req_b[0] = OPERAND_W'(100);
        bus.req_a[1] = OPERAND_W'(1);
        bus.req_b[1] = OPERAND_W'(100);
        bus.req_valid = 2'b11;
        #1;
        for (int j = 0; j < 8; j++) begin
            int g;
            g = j % 2;
            check("burst_grant", RESULT_W'(bus.req_ready), RESULT_W'(1) << g);
            push_exp(g, RESULT_W'(100 + j));
            $display("burst op=%0d grant=%b", j, bus.req_ready);
            step();
            check("burst_dv", RESULT_W'(adder_dv), RESULT_W'(1));
            check("burst_a", RESULT_W'(adder_a), RESULT_W'(j));
            bus.req_a[g] = OPERAND_W'(j + 2);
            if (j + 2 > 7) bus.req_valid[g] = 1'b0;
            #1;
        end
        step();
        check("burst_dv_end", RESULT_W'(adder_dv), '0);
        drain();

        // Req 1 always valid, req 0 toggling.
        do_reset();
        bus.req_a = {OPERAND_W'(7), OPERAND_W'(7)};
        bus.req_b = {OPERAND_W'(8), OPERAND_W'(8)};
        for (int w = 0; w < 8; w++) begin
            int g;
            bus.req_valid = (w % 2 == 0) ? 2'b11 : 2'b10;
            #1;
            g = (w % 2 == 0) ? 0 : 1;
            check("starve_grant", RESULT_W'(bus.req_ready), RESULT_W'(1) << g);
            push_exp(g, RESULT_W'(15));
            $display("starve cycle=%0d valid=%b grant=%b", w, bus.req_valid, bus.req_ready);
            step();
        end
        bus.req_valid = '0;
        drain();

        // Reset two cycles after an issue drops that op and restarts at requester 0.
        do_reset();
        bus.req_a[0] = OPERAND_W'(11);
        bus.req_b[0] = OPERAND_W'(22);
        bus.req_valid = 2'b01;
        #1;
        check("rst_pre_grant", RESULT_W'(bus.req_ready), RESULT_W'(1));
        step();
        bus.req_valid = '0;
        check("rst_pre_dv", RESULT_W'(adder_dv), RESULT_W'(1));
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outstanding", RESULT_W'(dut.outstanding_reg), '0);
        for (int w = 0; w < 8; w++) step();
        check("rst_outstanding_later", RESULT_W'(dut.outstanding_reg), '0);
`ifndef ADDER_ARB_CHECK_EN
        check("err_tied_low", RESULT_W'(err), '0);
`endif
        bus.req_a[1] = OPERAND_W'(30);
        bus.req_b[1] = OPERAND_W'(40);
        bus.req_valid = 2'b11;
        #1;
        check("rst_restart_grant", RESULT_W'(bus.req_ready), RESULT_W'(2'b01));
        push_exp(0, RESULT_W'(33));
        step();
        bus.req_valid = 2'b10;
        #1;
        check("rst_second_grant", RESULT_W'(bus.req_ready), RESULT_W'(2'b10));
        push_exp(1, RESULT_W'(70));
        step();
        bus.req_valid = '0;
        drain();
        $display("reset-during-op sequence done");

`ifdef ADDER_ARB_CHECK_EN
        do_reset();
        check("err_clear", RESULT_W'(err), '0);
        inject_o_dv = 1'b1;
        step();
        inject_o_dv = 1'b0;
        check("err_set", RESULT_W'(err), RESULT_W'(1));
        for (int w = 0; w < 3; w++) step();
        check("err_sticky", RESULT_W'(err), RESULT_W'(1));
        do_reset();
        check("err_reset", RESULT_W'(err), '0);
        $display("spurious o_dv sequence done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
